miso_rx: RTL and testbench
==========================

# miso_rx

SPI read-data receiver for the accelerometer interface: it samples MISO on strobes from the SPI clock generator and assembles a burst of bytes, e.g. the six XDATA/YDATA/ZDATA bytes. Bytes are presented to the register-file/display logic through a valid/ready handshake. It sits beside the instruction/address shifter, which drives MOSI, and is sequenced by the same SPI controller FSM.

## Interface
Parameters:
- NBYTES, 6, bytes per read burst; legal range 1..16.
- IDX_W, $clog2(NBYTES) (minimum 1), width of byte_idx.

Ports:
- ck  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  single-cycle pulse that begins a burst; honoured only in IDLE.
- sample_miso  in  1  single-cycle strobe, asserted at the SCLK rising edge; samples miso.
- miso  in  1  serial data from the accelerometer.
- byte_out  out  8  most recently assembled byte.
- byte_idx  out  IDX_W  burst position of byte_out, 0-based.
- byte_valid  out  1  byte_out/byte_idx hold a byte not yet consumed.
- byte_ready  in  1  consumer accepts the byte when byte_valid && byte_ready.
- busy  out  1  high in SHIFT.
- done  out  1  one-cycle pulse at end of burst.
- overrun  out  1  sticky flag: a byte was overwritten before it was accepted.

## Operation
- FSM states: IDLE, SHIFT, DONE.
  - IDLE -> SHIFT on start. On entry: clear bit_cnt, byte_cnt and overrun.
  - SHIFT -> DONE on the sample_miso that completes bit 7 of byte NBYTES-1.
  - DONE -> IDLE unconditionally after one cycle.
- start in SHIFT or DONE is ignored. sample_miso in IDLE or DONE is ignored; the shift register is untouched.
- Bit order is MSB first. Each strobe in SHIFT: shreg <= {shreg[6:0], miso}; bit_cnt increments, wrapping 7 -> 0.
- Byte completion is the strobe with bit_cnt == 7. On the next edge:
  - byte_out <= {shreg[6:0], miso}
  - byte_idx <= byte_cnt
  - byte_valid <= 1
  - byte_cnt increments
- Handshake:
  - byte_valid stays high and byte_out is held until a cycle with byte_ready high.
  - After that cycle byte_valid falls, unless a new byte loads on the same edge.
- Boundary cases for a byte completion:
  - byte_valid high and byte_ready high in the same cycle: the new byte loads, byte_valid stays 1, no overrun.
  - byte_valid high and byte_ready low: the new byte overwrites the old one and overrun <= 1.
- overrun is cleared only by rst or by a start accepted in IDLE.
- A pending byte_valid is not cleared by done or by returning to IDLE. It waits for byte_ready.

## Timing
- Reset values: byte_out 0, byte_idx 0, byte_valid 0, busy 0, done 0, overrun 0; state IDLE; shreg, bit_cnt and byte_cnt all 0.
- rst mid-burst aborts immediately: the next cycle matches the reset values and no done is produced.
- busy rises the cycle after start and falls the cycle after the final completing strobe.
- Latency: byte_valid rises exactly 1 cycle after the completing strobe.
- For the final byte, done pulses in the same cycle that byte_valid rises (the DONE state).
- Strobes may be back-to-back, one per cycle, with no loss.
- Burst length: exactly 8*NBYTES accepted strobes.

## Configuration
- MISO_RX_LSB_FIRST_EN
  - Defined: LSB-first assembly, shreg <= {miso, shreg[7:1]}; byte completion loads {miso, shreg[7:1]}.
  - Undefined: MSB-first as described in Operation.
- All counts, handshake and timing are identical in both builds.

## Structure
- Shared package acc_spi_pkg holds:
  - the state enum (IDLE, SHIFT, DONE)
  - BYTE_W = 8
  - ACC_BURST_BYTES = 6, shared with the SPI controller.
- One natural sub-module: miso_shreg, an 8-bit shifter plus 3-bit bit counter. It has inputs ck, rst, clr, sample, miso and outputs data and last_bit. The top module holds the FSM, byte counter, handshake and overrun.

## Test plan
- Basic burst: rst, then start; hold byte_ready=1; drive MSB-first bytes 0x5A, 0xC3, 0x01, 0x80, 0xFF, 0x00, one strobe every 4 cycles.
  - Expect six byte_valid pulses with matching byte_idx 0..5.
  - Expect done in the cycle of byte 5; busy low afterwards.
- Back-to-back strobes every cycle, NBYTES=2, bytes 0xA5, 0x3C: byte_valid 1 cycle after strobe 8 and after strobe 16; no overrun.
- Backpressure: byte_ready=0 through two completions (0x11 then 0x22).
  - Expect overrun=1 and byte_out=0x22 held.
  - Raise byte_ready: byte_valid falls next cycle; overrun stays 1 until the next start.
- Accept and complete in the same cycle: byte_ready=1 exactly when the next byte completes. Expect byte_valid to stay 1 with the new byte and overrun=0.
- Ignored inputs: start mid-burst has no effect on counts; strobes in IDLE leave byte_valid 0 and done 0.
- rst asserted after 13 strobes: all outputs return to reset values next cycle. A new start then receives a full 6-byte burst correctly.
  - Repeat in a MISO_RX_LSB_FIRST_EN build: serial 0x5A MSB-first sequence must yield 0x5A bit-reversed, i.e. 0x5A.
  - Serial MSB-first 0x01 must yield 0x80.

Source files
------------

// File: rtl/acc_spi_pkg.sv
// Shared definitions for the accelerometer SPI datapath: receiver FSM states and burst sizing.
// Used by miso_rx and miso_shreg (both honour the MISO_RX_LSB_FIRST_EN build option).
package acc_spi_pkg;

  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned ACC_BURST_BYTES = 6;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } rx_state_e;

  // Index width for a burst of n bytes; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/miso_shreg.sv
// 8-bit MISO shift register with 3-bit bit counter; last_bit flags the strobe that closes a byte.
// MISO_RX_LSB_FIRST_EN selects LSB-first shifting; MSB-first otherwise.
module miso_shreg
  import acc_spi_pkg::*;
(
  input  logic              ck,
  input  logic              rst,
  input  logic              clr,
  input  logic              sample,
  input  logic              miso,
  output logic [BYTE_W-1:0] data,
  output logic              last_bit
);

  logic [BYTE_W-1:0] shreg_q, shreg_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;

  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    if (clr) begin
      shreg_d   = '0;
      bit_cnt_d = '0;
    end else if (sample) begin
`ifdef MISO_RX_LSB_FIRST_EN
      shreg_d = {miso, shreg_q[BYTE_W-1:1]};
`else
      shreg_d = {shreg_q[BYTE_W-2:0], miso};
`endif
      // Natural 3-bit wrap takes 7 back to 0.
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign data     = shreg_q;
  assign last_bit = (bit_cnt_q == 3'd7);

endmodule

// File: rtl/miso_rx.sv
// SPI read-data receiver: assembles a burst of NBYTES bytes from MISO and hands them out via
// valid/ready. Build option MISO_RX_LSB_FIRST_EN switches byte assembly to LSB-first.
module miso_rx
  import acc_spi_pkg::*;
#(
  parameter int unsigned NBYTES = ACC_BURST_BYTES,
  parameter int unsigned IDX_W  = idx_width(NBYTES)
) (
  input  logic              ck,
  input  logic              rst,
  input  logic              start,
  input  logic              sample_miso,
  input  logic              miso,
  output logic [BYTE_W-1:0] byte_out,
  output logic [IDX_W-1:0]  byte_idx,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  rx_state_e         state_q, state_d;
  logic [IDX_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [BYTE_W-1:0] byte_out_q, byte_out_d;
  logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
  logic              byte_valid_q, byte_valid_d;
  logic              overrun_q, overrun_d;

  logic              clr;
  logic              sample_en;
  logic              byte_done;
  logic              last_byte;
  logic              last_bit;
  logic [BYTE_W-1:0] sh_data;
  logic [BYTE_W-1:0] assembled;

  miso_shreg u_shreg (
    .ck       (ck),
    .rst      (rst),
    .clr      (clr),
    .sample   (sample_en),
    .miso     (miso),
    .data     (sh_data),
    .last_bit (last_bit)
  );

  // The completing byte includes the bit arriving on this strobe, so one shreg bit drops out.
`ifdef MISO_RX_LSB_FIRST_EN
  logic unused_lsb;
  assign assembled  = {miso, sh_data[BYTE_W-1:1]};
  assign unused_lsb = sh_data[0];
`else
  logic unused_msb;
  assign assembled  = {sh_data[BYTE_W-2:0], miso};
  assign unused_msb = sh_data[BYTE_W-1];
`endif

  assign sample_en = sample_miso && (state_q == StShift);
  assign byte_done = sample_en && last_bit;
  assign last_byte = (byte_cnt_q == IDX_W'(NBYTES - 1));

  always_comb begin
    state_d      = state_q;
    clr          = 1'b0;
    byte_cnt_d   = byte_cnt_q;
    byte_out_d   = byte_out_q;
    byte_idx_d   = byte_idx_q;
    byte_valid_d = byte_valid_q;
    overrun_d    = overrun_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StShift;
          clr        = 1'b1;
          byte_cnt_d = '0;
          overrun_d  = 1'b0;
        end
      end
      StShift: begin
        if (byte_done && last_byte) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A pending byte survives done/IDLE; only the consumer or reset clears it.
    if (byte_valid_q && byte_ready) byte_valid_d = 1'b0;

    if (byte_done) begin
      byte_out_d   = assembled;
      byte_idx_d   = byte_cnt_q;
      byte_valid_d = 1'b1;
      byte_cnt_d   = byte_cnt_q + IDX_W'(1);
      if (byte_valid_q && !byte_ready) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q      <= StIdle;
      byte_cnt_q   <= '0;
      byte_out_q   <= '0;
      byte_idx_q   <= '0;
      byte_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      byte_out_q   <= byte_out_d;
      byte_idx_q   <= byte_idx_d;
      byte_valid_q <= byte_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign byte_out   = byte_out_q;
  assign byte_idx   = byte_idx_q;
  assign byte_valid = byte_valid_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q == StShift);
  assign done       = (state_q == StDone);

endmodule

// File: tb/tb_miso_rx.sv
// Scoreboard bench for miso_rx: stimulus queues the bytes a consumer must receive, a negedge
// monitor checks every accepted byte and done pulse. Honours MISO_RX_LSB_FIRST_EN.
module tb_miso_rx;
  import acc_spi_pkg::*;

  localparam int unsigned NB = ACC_BURST_BYTES;
  localparam int unsigned IW = 3;

  logic          ck = 1'b0;
  logic          rst, start, sample_miso, miso, byte_ready;
  logic [7:0]    byte_out;
  logic [IW-1:0] byte_idx;
  logic          byte_valid, busy, done, overrun;

  miso_rx #(
    .NBYTES (NB),
    .IDX_W  (IW)
  ) dut (
    .ck          (ck),
    .rst         (rst),
    .start       (start),
    .sample_miso (sample_miso),
    .miso        (miso),
    .byte_out    (byte_out),
    .byte_idx    (byte_idx),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun)
  );

  always #5 ck = ~ck;

  int cyc = 0;
  always @(posedge ck) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         idx;
    int         at;    // expected acceptance cycle, -1 when latency is not checked
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   checks = 0;
  int   errors = 0;

  // Serial stream is always sent v[7] first; the receiver's bit order decides the byte seen.
  function automatic logic [7:0] model_byte(input logic [7:0] v);
    logic [7:0] r;
`ifdef MISO_RX_LSB_FIRST_EN
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
`else
    r = v;
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_byte_out"},   32'(byte_out),   32'd0);
    chk({tag, "_byte_idx"},   32'(byte_idx),   32'd0);
    chk({tag, "_byte_valid"}, 32'(byte_valid), 32'd0);
    chk({tag, "_busy"},       32'(busy),       32'd0);
    chk({tag, "_done"},       32'(done),       32'd0);
    chk({tag, "_overrun"},    32'(overrun),    32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start",    32'(busy),    32'd1);
    chk("overrun_after_start", 32'(overrun), 32'd0);
  endtask

  // mode: 0 no expectation, 1 expect with exact latency, 2 expect without latency check.
  task automatic send_byte(input logic [7:0] v, input int idx, input int gap_lo, input int gap_hi,
                           input int mode, input bit last, input bit ready_on_last);
    for (int i = 7; i >= 0; i--) begin
      sample_miso = 1'b1;
      miso        = v[i];
      if (i == 0) begin
        if (ready_on_last) byte_ready = 1'b1;
        if (mode == 1) exp_q.push_back('{model_byte(v), idx, cyc + 1});
        if (mode == 2) exp_q.push_back('{model_byte(v), idx, -1});
        if (last) done_q.push_back(cyc + 1);
      end
      tick();
      sample_miso = 1'b0;
      miso        = 1'($urandom);
      repeat ($urandom_range(gap_hi, gap_lo)) tick();
    end
  endtask

  task automatic run_burst(input logic [7:0] vals [NB], input int gap_lo, input int gap_hi,
                           input bit poke);
    byte_ready = 1'b1;
    pulse_start();
    for (int b = 0; b < int'(NB); b++) begin
      if (poke && b == 3) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      send_byte(vals[b], b, gap_lo, gap_hi, 1, b == int'(NB) - 1, 1'b0);
    end
    tick();
    chk("busy_after_burst", 32'(busy), 32'd0);
  endtask

  exp_t mon_e;
  int   mon_d;
  always @(negedge ck) begin
    if (!rst) begin
      if (byte_valid && byte_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got 0x%0h idx %0d, expected none", byte_out, byte_idx);
        end else begin
          mon_e = exp_q.pop_front();
          chk("byte_out", 32'(byte_out), 32'(mon_e.data));
          chk("byte_idx", 32'(byte_idx), 32'(mon_e.idx));
          if (mon_e.at >= 0) chk("byte_latency", 32'(cyc), 32'(mon_e.at));
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
        end else begin
          mon_d = done_q.pop_front();
          chk("done_cycle",   32'(cyc),  32'(mon_d));
          chk("busy_in_done", 32'(busy), 32'd0);
        end
      end
    end
  end

  logic [7:0] vals [NB];

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    sample_miso = 1'b0;
    miso        = 1'b0;
    byte_ready  = 1'b1;
    tick();
    tick();
    check_reset("reset");
    rst = 1'b0;
    tick();

    // Basic burst, one strobe every 4 cycles.
    vals = '{8'h5A, 8'hC3, 8'h01, 8'h80, 8'hFF, 8'h00};
    run_burst(vals, 3, 3, 1'b0);

    // Back-to-back strobes.
    vals = '{8'hA5, 8'h3C, 8'h96, 8'h0F, 8'hF0, 8'h69};
    run_burst(vals, 0, 0, 1'b0);

    // Strobes in IDLE are ignored.
    send_byte(8'hFF, 0, 0, 1, 0, 1'b0, 1'b0);
    chk("idle_valid", 32'(byte_valid), 32'd0);
    chk("idle_done",  32'(done),       32'd0);
    chk("idle_busy",  32'(busy),       32'd0);

    // Backpressure through two completions: first byte lost, overrun sticky.
    pulse_start();
    byte_ready = 1'b0;
    send_byte(8'h11, 0, 0, 2, 0, 1'b0, 1'b0);
    send_byte(8'h22, 1, 0, 2, 0, 1'b0, 1'b0);
    chk("bp_overrun",  32'(overrun),    32'd1);
    chk("bp_valid",    32'(byte_valid), 32'd1);
    chk("bp_byte_out", 32'(byte_out),   32'(model_byte(8'h22)));
    chk("bp_byte_idx", 32'(byte_idx),   32'd1);
    exp_q.push_back('{model_byte(8'h22), 1, -1});
    byte_ready = 1'b1;
    tick();
    byte_ready = 1'b0;
    chk("bp_valid_fall",  32'(byte_valid), 32'd0);
    chk("bp_overrun_hold", 32'(overrun),   32'd1);
    byte_ready = 1'b1;
    for (int b = 2; b < int'(NB); b++)
      send_byte(8'($urandom), b, 0, 2, 1, b == int'(NB) - 1, 1'b0);
    tick();
    chk("bp_overrun_sticky", 32'(overrun), 32'd1);

    // Accept the pending byte on the same cycle the next one completes.
    pulse_start();
    byte_ready = 1'b0;
    send_byte(8'h33, 0, 0, 1, 2, 1'b0, 1'b0);
    send_byte(8'h44, 1, 0, 0, 1, 1'b0, 1'b1);
    chk("same_valid",    32'(byte_valid), 32'd1);
    chk("same_byte_out", 32'(byte_out),   32'(model_byte(8'h44)));
    chk("same_overrun",  32'(overrun),    32'd0);
    for (int b = 2; b < int'(NB); b++)
      send_byte(8'($urandom), b, 0, 1, 1, b == int'(NB) - 1, 1'b0);
    tick();
    chk("same_overrun_end", 32'(overrun), 32'd0);

    // Reset after 13 strobes aborts the burst without done.
    byte_ready = 1'b1;
    pulse_start();
    send_byte(8'($urandom), 0, 0, 1, 1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      sample_miso = 1'b1;
      miso        = 1'($urandom);
      tick();
      sample_miso = 1'b0;
    end
    rst = 1'b1;
    tick();
    check_reset("abort");
    rst = 1'b0;
    tick();
    for (int i = 0; i < int'(NB); i++) vals[i] = 8'($urandom);
    run_burst(vals, 0, 1, 1'b0);

    // Random bursts with a stray start mid-burst.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < int'(NB); i++) vals[i] = 8'($urandom);
      run_burst(vals, 0, 2, 1'b1);
    end

    repeat (4) tick();
    chk("bytes_outstanding", 32'(exp_q.size()),  32'd0);
    chk("done_outstanding",  32'(done_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
